// File: rtl/sys_cntr_rx_pkg.sv
// Shared system definitions for the UART receive-side command controller:
// command codes, fixed ALU operand register addresses and the FSM encoding.
package sys_cntr_rx_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WR_ADDR  = 4'd1,
    WR_DATA  = 4'd2,
    RD_ADDR  = 4'd3,
    RD_WAIT  = 4'd4,
    ALU_A    = 4'd5,
    ALU_B    = 4'd6,
    ALU_FN   = 4'd7,
    ALU_WAIT = 4'd8
  } cntr_rx_state_e;

endpackage

// File: rtl/sys_cntr_rx.sv
// Decodes received command bytes into register-file writes/reads and ALU
// operations; every output is registered and responds one cycle after its byte.
module sys_cntr_rx
  import sys_cntr_rx_pkg::*;
#(
  parameter int width      = 8,
  parameter int addr_width = 4
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [width-1:0]      Rx_Data,
  input  logic                  Rx_Data_valid,
  input  logic                  Rd_valid,
  input  logic                  ALU_out_valid,
  output logic [addr_width-1:0] Address,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [width-1:0]      WrData,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  CLK_GATE_EN,
  output logic                  Cmd_err
);

  localparam logic [width-1:0] CMD_WR_W      = width'(CMD_WR);
  localparam logic [width-1:0] CMD_RD_W      = width'(CMD_RD);
  localparam logic [width-1:0] CMD_ALU_OP_W  = width'(CMD_ALU_OP);
  localparam logic [width-1:0] CMD_ALU_NOP_W = width'(CMD_ALU_NOP);

  cntr_rx_state_e        state_q, state_d;
  logic [addr_width-1:0] addr_lat_q, addr_lat_d;
  logic [addr_width-1:0] address_q, address_d;
  logic [width-1:0]      wrdata_q, wrdata_d;
  logic [3:0]            alu_fun_q, alu_fun_d;
  logic                  wren_q, wren_d;
  logic                  rden_q, rden_d;
  logic                  alu_en_q, alu_en_d;
  logic                  gate_q, gate_d;
  logic                  err_q, err_d;
  logic                  cmd_byte;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      addr_lat_q <= '0;
      address_q  <= '0;
      wrdata_q   <= '0;
      alu_fun_q  <= '0;
      wren_q     <= 1'b0;
      rden_q     <= 1'b0;
      alu_en_q   <= 1'b0;
      gate_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_lat_q <= addr_lat_d;
      address_q  <= address_d;
      wrdata_q   <= wrdata_d;
      alu_fun_q  <= alu_fun_d;
      wren_q     <= wren_d;
      rden_q     <= rden_d;
      alu_en_q   <= alu_en_d;
      gate_q     <= gate_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_lat_d = addr_lat_q;
    address_d  = address_q;
    wrdata_d   = wrdata_q;
    alu_fun_d  = alu_fun_q;
    gate_d     = gate_q;
    wren_d     = 1'b0;
    rden_d     = 1'b0;
    alu_en_d   = 1'b0;
    err_d      = 1'b0;
    cmd_byte   = 1'b0;

    case (state_q)
      IDLE: cmd_byte = Rx_Data_valid;
      WR_ADDR: if (Rx_Data_valid) begin
        addr_lat_d = Rx_Data[addr_width-1:0];
        state_d    = WR_DATA;
      end
      WR_DATA: if (Rx_Data_valid) begin
        wren_d    = 1'b1;
        wrdata_d  = Rx_Data;
        address_d = addr_lat_q;
        state_d   = IDLE;
      end
      RD_ADDR: if (Rx_Data_valid) begin
        rden_d    = 1'b1;
        address_d = Rx_Data[addr_width-1:0];
        state_d   = RD_WAIT;
      end
      // A byte coinciding with the completion strobe starts the next command.
      RD_WAIT: begin
        if (Rd_valid) begin
          state_d  = IDLE;
          cmd_byte = Rx_Data_valid;
        end else if (Rx_Data_valid) begin
          err_d = 1'b1;
        end
      end
      ALU_A: if (Rx_Data_valid) begin
        wren_d    = 1'b1;
        wrdata_d  = Rx_Data;
        address_d = addr_width'(OPA_ADDR);
        state_d   = ALU_B;
      end
      ALU_B: if (Rx_Data_valid) begin
        wren_d    = 1'b1;
        wrdata_d  = Rx_Data;
        address_d = addr_width'(OPB_ADDR);
        state_d   = ALU_FN;
      end
      ALU_FN: if (Rx_Data_valid) begin
        alu_en_d  = 1'b1;
        alu_fun_d = Rx_Data[3:0];
        state_d   = ALU_WAIT;
      end
      ALU_WAIT: begin
        if (ALU_out_valid) begin
          state_d  = IDLE;
          gate_d   = 1'b0;
          cmd_byte = Rx_Data_valid;
        end else if (Rx_Data_valid) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Gate enable set here overrides the clear from a same-cycle ALU completion.
    if (cmd_byte) begin
      if (Rx_Data == CMD_WR_W) begin
        state_d = WR_ADDR;
      end else if (Rx_Data == CMD_RD_W) begin
        state_d = RD_ADDR;
      end else if (Rx_Data == CMD_ALU_OP_W) begin
        state_d = ALU_A;
        gate_d  = 1'b1;
      end else if (Rx_Data == CMD_ALU_NOP_W) begin
        state_d = ALU_FN;
        gate_d  = 1'b1;
      end else begin
        state_d = IDLE;
        err_d   = 1'b1;
      end
    end
  end

  assign Address     = address_q;
  assign WrEn        = wren_q;
  assign RdEn        = rden_q;
  assign WrData      = wrdata_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = gate_q;
  assign Cmd_err     = err_q;

endmodule

// File: tb/tb_sys_cntr_rx.sv
// Directed bench for sys_cntr_rx: command byte sequences with hand-computed
// register-file, ALU and error responses.
module tb_sys_cntr_rx;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [7:0] Rx_Data;
  logic       Rx_Data_valid;
  logic       Rd_valid;
  logic       ALU_out_valid;
  logic [3:0] Address;
  logic       WrEn;
  logic       RdEn;
  logic [7:0] WrData;
  logic       ALU_EN;
  logic [3:0] ALU_FUN;
  logic       CLK_GATE_EN;
  logic       Cmd_err;

  int n_cmp = 0;
  int n_bad = 0;

  sys_cntr_rx #(.width(8), .addr_width(4)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .Rx_Data      (Rx_Data),
    .Rx_Data_valid(Rx_Data_valid),
    .Rd_valid     (Rd_valid),
    .ALU_out_valid(ALU_out_valid),
    .Address      (Address),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .WrData       (WrData),
    .ALU_EN       (ALU_EN),
    .ALU_FUN      (ALU_FUN),
    .CLK_GATE_EN  (CLK_GATE_EN),
    .Cmd_err      (Cmd_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change #1 after a rising edge; outputs are sampled at that point too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    Rx_Data       = b;
    Rx_Data_valid = 1'b1;
    tick();
    Rx_Data_valid = 1'b0;
    Rx_Data       = 8'h00;
  endtask

  task automatic chk_pulses(input string tag, input logic wr, input logic rd,
                            input logic en, input logic err);
    chk({tag, ".WrEn"},    WrEn,    wr);
    chk({tag, ".RdEn"},    RdEn,    rd);
    chk({tag, ".ALU_EN"},  ALU_EN,  en);
    chk({tag, ".Cmd_err"}, Cmd_err, err);
  endtask

  initial begin
    Reset = 1'b0; Rx_Data = 8'h00; Rx_Data_valid = 1'b0;
    Rd_valid = 1'b0; ALU_out_valid = 1'b0;
    tick(); tick();
    chk("rst.Address", Address, 4'h0);
    chk("rst.WrData", WrData, 8'h00);
    chk("rst.ALU_FUN", ALU_FUN, 4'h0);
    chk("rst.GATE", CLK_GATE_EN, 1'b0);
    chk_pulses("rst", 0, 0, 0, 0);
    Reset = 1'b1;
    tick();

    // Write: AA,05,3C
    send(8'hAA); chk_pulses("wr.aa", 0, 0, 0, 0);
    send(8'h05); chk_pulses("wr.addr", 0, 0, 0, 0);
    chk("wr.addr.Address", Address, 4'h0);
    send(8'h3C); chk_pulses("wr.data", 1, 0, 0, 0);
    chk("wr.Address", Address, 4'h5);
    chk("wr.WrData", WrData, 8'h3C);
    tick(); chk_pulses("wr.after", 0, 0, 0, 0);
    chk("wr.hold.Address", Address, 4'h5);

    // Rd_valid in IDLE is ignored
    Rd_valid = 1'b1; tick(); Rd_valid = 1'b0;
    chk_pulses("idle.rdv", 0, 0, 0, 0);

    // Read: BB,12 -> address 2; stray 77 -> error
    send(8'hBB); chk_pulses("rd.bb", 0, 0, 0, 0);
    send(8'h12); chk_pulses("rd.addr", 0, 1, 0, 0);
    chk("rd.Address", Address, 4'h2);
    send(8'h77); chk_pulses("rd.stray", 0, 0, 0, 1);
    tick(); chk_pulses("rd.after", 0, 0, 0, 0);
    Rd_valid = 1'b1; tick(); Rd_valid = 1'b0;
    chk_pulses("rd.done", 0, 0, 0, 0);

    // ALU with operands: CC,0A,03,01
    send(8'hCC); chk_pulses("alu.cc", 0, 0, 0, 0);
    chk("alu.cc.GATE", CLK_GATE_EN, 1'b1);
    send(8'h0A); chk_pulses("alu.a", 1, 0, 0, 0);
    chk("alu.a.Address", Address, 4'h0);
    chk("alu.a.WrData", WrData, 8'h0A);
    send(8'h03); chk_pulses("alu.b", 1, 0, 0, 0);
    chk("alu.b.Address", Address, 4'h1);
    chk("alu.b.WrData", WrData, 8'h03);
    chk("alu.b.GATE", CLK_GATE_EN, 1'b1);
    send(8'h01); chk_pulses("alu.fn", 0, 0, 1, 0);
    chk("alu.fn.FUN", ALU_FUN, 4'h1);
    tick(); chk_pulses("alu.wait", 0, 0, 0, 0);
    chk("alu.wait.GATE", CLK_GATE_EN, 1'b1);
    chk("alu.wait.FUN", ALU_FUN, 4'h1);
    ALU_out_valid = 1'b1; tick(); ALU_out_valid = 1'b0;
    chk("alu.done.GATE", CLK_GATE_EN, 1'b0);
    chk("alu.done.FUN", ALU_FUN, 4'h1);

    // ALU without operands, then AA together with ALU_out_valid
    send(8'hDD); chk("nop.dd.GATE", CLK_GATE_EN, 1'b1);
    chk_pulses("nop.dd", 0, 0, 0, 0);
    send(8'h08); chk_pulses("nop.fn", 0, 0, 1, 0);
    chk("nop.fn.FUN", ALU_FUN, 4'h8);
    ALU_out_valid = 1'b1; send(8'hAA); ALU_out_valid = 1'b0;
    chk_pulses("b2b.aa", 0, 0, 0, 0);
    chk("b2b.GATE", CLK_GATE_EN, 1'b0);
    send(8'h07); send(8'h99);
    chk_pulses("b2b.wr", 1, 0, 0, 0);
    chk("b2b.Address", Address, 4'h7);
    chk("b2b.WrData", WrData, 8'h99);
    chk("b2b.FUN", ALU_FUN, 4'h8);

    // Error in IDLE
    send(8'h55); chk_pulses("err.55", 0, 0, 0, 1);
    tick(); chk_pulses("err.after", 0, 0, 0, 0);

    // Reset mid-command
    send(8'hCC); send(8'h0A);
    chk("mid.WrEn", WrEn, 1'b1);
    Reset = 1'b0; #1;
    chk("mrst.Address", Address, 4'h0);
    chk("mrst.WrData", WrData, 8'h00);
    chk("mrst.ALU_FUN", ALU_FUN, 4'h0);
    chk("mrst.GATE", CLK_GATE_EN, 1'b0);
    chk_pulses("mrst", 0, 0, 0, 0);
    tick();
    Reset = 1'b1;
    tick(); chk_pulses("mrst.release", 0, 0, 0, 0);
    send(8'h03); chk_pulses("mrst.03", 0, 0, 0, 1);
    chk("mrst.03.GATE", CLK_GATE_EN, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
